mini_cpu: RTL and testbench



---
 rtl/mini_cpu_pkg.sv | 85 ++++++++
 rtl/mini_cpu_lcd.sv | 207 ++++++++++++++++++++
 rtl/mini_cpu.sv | 123 ++++++++++++
 tb/tb_mini_cpu.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_cpu_pkg.sv
// Shared constants for the mini CPU: opcodes, LCD command bytes, character
// codes, timing values and small conversion helpers.
package mini_cpu_pkg;

   typedef enum logic [2:0] {
      OP_LOAD  = 3'b000,
      OP_ADD   = 3'b001,
      OP_ADDI  = 3'b010,
      OP_SUB   = 3'b011,
      OP_SUBI  = 3'b100,
      OP_MUL   = 3'b101,
      OP_CLEAR = 3'b110,
      OP_DPL   = 3'b111
   } opcode_e;

   typedef enum logic [1:0] {
      ST_PWRWAIT = 2'd0,
      ST_INIT    = 2'd1,
      ST_IDLE    = 2'd2,
      ST_SEND    = 2'd3
   } lcd_state_e;

   localparam logic [7:0] CMD_FUNC    = 8'h38;
   localparam logic [7:0] CMD_DISP_ON = 8'h0C;
   localparam logic [7:0] CMD_ENTRY   = 8'h06;
   localparam logic [7:0] CMD_CLEAR   = 8'h01;
   localparam logic [7:0] CMD_LINE1   = 8'h80;
   localparam logic [7:0] CMD_LINE2   = 8'hC0;

   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_LBR   = 8'h5B;
   localparam logic [7:0] CH_RBR   = 8'h5D;
   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_MINUS = 8'h2D;
   localparam logic [3:0] CH_DIGIT_HI = 4'h3;

   localparam logic [39:0] MN_LOAD  = "LOAD ";
   localparam logic [39:0] MN_ADD   = "ADD  ";
   localparam logic [39:0] MN_ADDI  = "ADDI ";
   localparam logic [39:0] MN_SUB   = "SUB  ";
   localparam logic [39:0] MN_SUBI  = "SUBI ";
   localparam logic [39:0] MN_MUL   = "MUL  ";
   localparam logic [39:0] MN_CLEAR = "CLEAR";
   localparam logic [39:0] MN_DPL   = "DPL  ";

   localparam logic [20:0] T_PWR_SLOW  = 21'd1000000;
   localparam logic [20:0] T_EN_SLOW   = 21'd12;
   localparam logic [20:0] T_BYTE_SLOW = 21'd2500;
   localparam logic [20:0] T_CLR_SLOW  = 21'd100000;
   localparam logic [20:0] T_PWR_FAST  = 21'd16;
   localparam logic [20:0] T_EN_FAST   = 21'd2;
   localparam logic [20:0] T_BYTE_FAST = 21'd4;
   localparam logic [20:0] T_CLR_FAST  = 21'd8;

   function automatic logic [7:0] mnem_char(input opcode_e op, input logic [2:0] pos);
      logic [39:0] s;
      case (op)
         OP_LOAD:  s = MN_LOAD;
         OP_ADD:   s = MN_ADD;
         OP_ADDI:  s = MN_ADDI;
         OP_SUB:   s = MN_SUB;
         OP_SUBI:  s = MN_SUBI;
         OP_MUL:   s = MN_MUL;
         OP_CLEAR: s = MN_CLEAR;
         OP_DPL:   s = MN_DPL;
         default:  s = MN_DPL;
      endcase
      s = s << {pos, 3'b000};
      return s[39:32];
   endfunction

   // Double-dabble: five BCD digits are enough for magnitudes up to 32768.
   function automatic logic [19:0] bin2bcd(input logic [15:0] bin);
      logic [19:0] bcd;
      bcd = 20'h00000;
      for (int i = 15; i >= 0; i--) begin
         for (int d = 0; d < 5; d++) begin
            bcd[4*d +: 4] = (bcd[4*d +: 4] > 4'd4) ? (bcd[4*d +: 4] + 4'd3) : bcd[4*d +: 4];
         end
         bcd = {bcd[18:0], bin[i]};
      end
      return bcd;
   endfunction

endpackage

// File: rtl/mini_cpu_lcd.sv
// HD44780 8-bit write-only driver: power-up wait, init sequence, and a
// two-line refresh rendered from a snapshot of the last executed instruction.
module mini_cpu_lcd
   import mini_cpu_pkg::*;
#(
   parameter bit FAST_SIM = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        power_i,
   input  logic        refresh_i,
   input  opcode_e     op_i,
   input  logic [3:0]  rd_i,
   input  logic [15:0] val_i,
   output logic        lcd_rs_o,
   output logic        lcd_en_o,
   output logic [7:0]  lcd_data_o
);

   localparam logic [20:0] T_PWR_C  = FAST_SIM ? T_PWR_FAST  : T_PWR_SLOW;
   localparam logic [20:0] T_EN_C   = FAST_SIM ? T_EN_FAST   : T_EN_SLOW;
   localparam logic [20:0] T_BYTE_C = FAST_SIM ? T_BYTE_FAST : T_BYTE_SLOW;
   localparam logic [20:0] T_CLR_C  = FAST_SIM ? T_CLR_FAST  : T_CLR_SLOW;

   lcd_state_e  state_q, state_d;
   logic [20:0] ph_q, ph_d;
   logic [5:0]  idx_q, idx_d;
   logic        pending_q, pending_d;
   logic        power_prev_q;
   opcode_e     snap_op_q, snap_op_d;
   logic [3:0]  snap_rd_q, snap_rd_d;
   logic [15:0] snap_val_q, snap_val_d;
   logic        rs_q, rs_d, en_q, en_d;
   logic [7:0]  data_q, data_d;

   logic [7:0]  byte_s;
   logic        rs_s;
   logic [3:0]  pos_s;
   logic [15:0] mag_s;
   logic [19:0] bcd_s;
   logic [20:0] len_s;
   logic [5:0]  last_s;
   logic        pwr_rise_s;
   logic        en_win_s;

   assign mag_s      = snap_val_q[15] ? (~snap_val_q + 16'd1) : snap_val_q;
   assign bcd_s      = bin2bcd(mag_s);
   assign pwr_rise_s = power_i & ~power_prev_q;
   assign en_win_s   = (ph_q >= 21'd1) && (ph_q <= T_EN_C);
   assign last_s     = (state_q == ST_INIT) ? 6'd3 : 6'd33;
   assign len_s      = ((state_q == ST_INIT) && (idx_q == 6'd3)) ? T_CLR_C : T_BYTE_C;

   // Byte selection: idx 0 and 17 are cursor commands, the rest are characters.
   always_comb begin
      byte_s = CH_SPACE;
      rs_s   = 1'b1;
      pos_s  = 4'd0;
      if (state_q == ST_INIT) begin
         rs_s = 1'b0;
         case (idx_q[1:0])
            2'd0:    byte_s = CMD_FUNC;
            2'd1:    byte_s = CMD_DISP_ON;
            2'd2:    byte_s = CMD_ENTRY;
            default: byte_s = CMD_CLEAR;
         endcase
      end else if (idx_q == 6'd0) begin
         rs_s   = 1'b0;
         byte_s = CMD_LINE1;
      end else if (idx_q == 6'd17) begin
         rs_s   = 1'b0;
         byte_s = CMD_LINE2;
      end else if (idx_q < 6'd17) begin
         pos_s = 4'(idx_q - 6'd1);
         case (pos_s)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: byte_s = mnem_char(snap_op_q, pos_s[2:0]);
            4'd6:    byte_s = CH_LBR;
            4'd7:    byte_s = {7'b0011000, snap_rd_q[3]};
            4'd8:    byte_s = {7'b0011000, snap_rd_q[2]};
            4'd9:    byte_s = {7'b0011000, snap_rd_q[1]};
            4'd10:   byte_s = {7'b0011000, snap_rd_q[0]};
            4'd11:   byte_s = CH_RBR;
            default: byte_s = CH_SPACE;
         endcase
      end else begin
         pos_s = 4'(idx_q - 6'd18);
         case (pos_s)
            4'd10:   byte_s = snap_val_q[15] ? CH_MINUS : CH_PLUS;
            4'd11:   byte_s = {CH_DIGIT_HI, bcd_s[19:16]};
            4'd12:   byte_s = {CH_DIGIT_HI, bcd_s[15:12]};
            4'd13:   byte_s = {CH_DIGIT_HI, bcd_s[11:8]};
            4'd14:   byte_s = {CH_DIGIT_HI, bcd_s[7:4]};
            4'd15:   byte_s = {CH_DIGIT_HI, bcd_s[3:0]};
            default: byte_s = CH_SPACE;
         endcase
      end
   end

   // Next-state: power gating first, then the per-byte phase counter.
   always_comb begin
      state_d    = state_q;
      ph_d       = ph_q;
      idx_d      = idx_q;
      pending_d  = pending_q;
      snap_op_d  = snap_op_q;
      snap_rd_d  = snap_rd_q;
      snap_val_d = snap_val_q;
      rs_d       = rs_q;
      data_d     = data_q;
      en_d       = 1'b0;
      if (!power_i) begin
         state_d   = ST_IDLE;
         ph_d      = 21'd0;
         idx_d     = 6'd0;
         pending_d = 1'b0;
      end else if (pwr_rise_s) begin
         state_d   = ST_PWRWAIT;
         ph_d      = 21'd0;
         idx_d     = 6'd0;
         pending_d = refresh_i;
      end else begin
         if (refresh_i && (state_q != ST_IDLE)) begin
            pending_d = 1'b1;
         end else begin
            pending_d = pending_q;
         end
         case (state_q)
            ST_PWRWAIT: begin
               if (ph_q == T_PWR_C - 21'd1) begin
                  state_d = ST_INIT;
                  ph_d    = 21'd0;
                  idx_d   = 6'd0;
               end else begin
                  ph_d = ph_q + 21'd1;
               end
            end
            ST_INIT, ST_SEND: begin
               rs_d   = rs_s;
               data_d = byte_s;
               en_d   = en_win_s;
               if (ph_q == len_s - 21'd1) begin
                  ph_d = 21'd0;
                  if (idx_q == last_s) begin
                     state_d = ST_IDLE;
                     idx_d   = 6'd0;
                  end else begin
                     idx_d = idx_q + 6'd1;
                  end
               end else begin
                  ph_d = ph_q + 21'd1;
               end
            end
            ST_IDLE: begin
               if (refresh_i || pending_q) begin
                  state_d    = ST_SEND;
                  pending_d  = 1'b0;
                  snap_op_d  = op_i;
                  snap_rd_d  = rd_i;
                  snap_val_d = val_i;
                  ph_d       = 21'd0;
                  idx_d      = 6'd0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_PWRWAIT;
               ph_d    = 21'd0;
               idx_d   = 6'd0;
            end
         endcase
      end
   end

   // State and registered LCD outputs; reset aborts any transfer at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_PWRWAIT;
         ph_q         <= 21'd0;
         idx_q        <= 6'd0;
         pending_q    <= 1'b0;
         power_prev_q <= 1'b0;
         snap_op_q    <= OP_LOAD;
         snap_rd_q    <= 4'd0;
         snap_val_q   <= 16'h0000;
         rs_q         <= 1'b0;
         en_q         <= 1'b0;
         data_q       <= 8'h00;
      end else begin
         state_q      <= state_d;
         ph_q         <= ph_d;
         idx_q        <= idx_d;
         pending_q    <= pending_d;
         power_prev_q <= power_i;
         snap_op_q    <= snap_op_d;
         snap_rd_q    <= snap_rd_d;
         snap_val_q   <= snap_val_d;
         rs_q         <= rs_d;
         en_q         <= en_d;
         data_q       <= data_d;
      end
   end

   assign lcd_rs_o   = rs_q;
   assign lcd_en_o   = en_q;
   assign lcd_data_o = data_q;

endmodule

// File: rtl/mini_cpu.sv
// Board top: button synchronizer, instruction decode, 16x16 register file
// and ALU; every executed instruction triggers an LCD refresh.
module mini_cpu
   import mini_cpu_pkg::*;
#(
   parameter bit FAST_SIM = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        power_on,
   input  logic        btn_enviar,
   input  logic [17:0] instrucao,
   output logic        LCD_RS,
   output logic        LCD_EN,
   output logic        LCD_RW,
   output logic [7:0]  LCD_DATA,
   output logic        LCD_ON,
   output logic        LCD_BLON
);

   logic        power_q;
   logic        btn_meta_q, btn_sync_q, btn_prev_q;
   logic [15:0] regs_q [16];
   logic        refresh_q;
   opcode_e     snap_op_q;
   logic [3:0]  snap_rd_q;
   logic [15:0] snap_val_q;

   opcode_e     op_s;
   logic [3:0]  rd_s, rs1_s, rs2_s;
   logic [15:0] imm_s, a_s, b_s, mul_s, result_s;
   logic        wr_s, exec_s;

   assign op_s   = opcode_e'(instrucao[17:15]);
   assign rd_s   = instrucao[14:11];
   assign rs1_s  = instrucao[10:7];
   assign rs2_s  = instrucao[3:0];
   assign imm_s  = instrucao[6] ? (16'h0000 - {10'd0, instrucao[5:0]}) : {10'd0, instrucao[5:0]};
   assign a_s    = regs_q[rs1_s];
   assign b_s    = regs_q[rs2_s];
   assign mul_s  = a_s * b_s;
   assign exec_s = btn_sync_q & ~btn_prev_q & power_q;

   // ALU; the result doubles as the post-execution Rd value shown on the LCD.
   always_comb begin
      result_s = 16'h0000;
      wr_s     = 1'b1;
      case (op_s)
         OP_LOAD:  result_s = imm_s;
         OP_ADD:   result_s = a_s + b_s;
         OP_ADDI:  result_s = a_s + imm_s;
         OP_SUB:   result_s = a_s - b_s;
         OP_SUBI:  result_s = a_s - imm_s;
         OP_MUL:   result_s = mul_s;
         OP_CLEAR: wr_s     = 1'b0;
         OP_DPL: begin
            result_s = regs_q[rd_s];
            wr_s     = 1'b0;
         end
         default:  wr_s     = 1'b0;
      endcase
   end

   // Power level, button synchronizer/edge history and refresh snapshot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         power_q    <= 1'b0;
         btn_meta_q <= 1'b0;
         btn_sync_q <= 1'b0;
         btn_prev_q <= 1'b0;
         refresh_q  <= 1'b0;
         snap_op_q  <= OP_LOAD;
         snap_rd_q  <= 4'd0;
         snap_val_q <= 16'h0000;
      end else begin
         power_q    <= power_on;
         btn_meta_q <= btn_enviar;
         btn_sync_q <= btn_meta_q;
         btn_prev_q <= btn_sync_q;
         refresh_q  <= exec_s;
         if (exec_s) begin
            snap_op_q  <= op_s;
            snap_rd_q  <= rd_s;
            snap_val_q <= result_s;
         end
      end
   end

   // Register file; held at zero whenever the panel is powered off.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= 16'h0000;
         end
      end else if (!power_q || (exec_s && (op_s == OP_CLEAR))) begin
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= 16'h0000;
         end
      end else if (exec_s && wr_s) begin
         regs_q[rd_s] <= result_s;
      end
   end

   mini_cpu_lcd #(
      .FAST_SIM (FAST_SIM)
   ) u_lcd (
      .clk        (clk),
      .rst_n      (reset_n),
      .power_i    (power_q),
      .refresh_i  (refresh_q),
      .op_i       (snap_op_q),
      .rd_i       (snap_rd_q),
      .val_i      (snap_val_q),
      .lcd_rs_o   (LCD_RS),
      .lcd_en_o   (LCD_EN),
      .lcd_data_o (LCD_DATA)
   );

   assign LCD_RW   = 1'b0;
   assign LCD_ON   = power_q;
   assign LCD_BLON = power_q;

endmodule

// File: tb/tb_mini_cpu.sv
// Scoreboard bench for mini_cpu: expected LCD bytes are queued as stimulus
// is applied and compared as each EN strobe falls.
module tb_mini_cpu;

   logic        clk = 1'b0;
   logic        reset_n, power_on, btn_enviar;
   logic [17:0] instrucao;
   logic        LCD_RS, LCD_EN, LCD_RW, LCD_ON, LCD_BLON;
   logic [7:0]  LCD_DATA;

   int          n_checks = 0;
   int          n_errors = 0;
   int          en_rises = 0;
   logic        en_prev = 1'b0;
   logic [8:0]  sb_q [$];
   logic [15:0] m_regs [16];

   mini_cpu #(.FAST_SIM(1'b1)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .power_on   (power_on),
      .btn_enviar (btn_enviar),
      .instrucao  (instrucao),
      .LCD_RS     (LCD_RS),
      .LCD_EN     (LCD_EN),
      .LCD_RW     (LCD_RW),
      .LCD_DATA   (LCD_DATA),
      .LCD_ON     (LCD_ON),
      .LCD_BLON   (LCD_BLON)
   );

   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Byte monitor: a falling EN is one byte latched by the display.
   always @(negedge clk) begin
      if (!reset_n) begin
         en_prev <= 1'b0;
      end else begin
         if (LCD_EN && !en_prev) en_rises <= en_rises + 1;
         if (!LCD_EN && en_prev) begin
            check_eq("sb_nonempty", (sb_q.size() != 0), 32'd1);
            check_eq("lcd_rw", LCD_RW, 32'd0);
            if (sb_q.size() != 0) check_eq("lcd_byte", {LCD_RS, LCD_DATA}, sb_q.pop_front());
         end
         en_prev <= LCD_EN;
      end
   end

   task automatic clear_model();
      for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
   endtask

   task automatic push_init();
      sb_q.push_back(9'h038);
      sb_q.push_back(9'h00C);
      sb_q.push_back(9'h006);
      sb_q.push_back(9'h001);
   endtask

   task automatic push_frame(input logic [2:0] op, input logic [3:0] rd, input logic [15:0] val);
      string mn;
      int v, mag, p;
      case (op)
         3'd0: mn = "LOAD ";
         3'd1: mn = "ADD  ";
         3'd2: mn = "ADDI ";
         3'd3: mn = "SUB  ";
         3'd4: mn = "SUBI ";
         3'd5: mn = "MUL  ";
         3'd6: mn = "CLEAR";
         default: mn = "DPL  ";
      endcase
      sb_q.push_back(9'h080);
      for (int i = 0; i < 5; i++) sb_q.push_back({1'b1, 8'(mn[i])});
      sb_q.push_back(9'h120);
      sb_q.push_back(9'h15B);
      for (int b = 3; b >= 0; b--) sb_q.push_back({1'b1, (rd[b] ? 8'h31 : 8'h30)});
      sb_q.push_back(9'h15D);
      for (int i = 0; i < 4; i++) sb_q.push_back(9'h120);
      sb_q.push_back(9'h0C0);
      for (int i = 0; i < 10; i++) sb_q.push_back(9'h120);
      v = int'($signed(val));
      sb_q.push_back({1'b1, (v < 0) ? 8'h2D : 8'h2B});
      mag = (v < 0) ? -v : v;
      p = 10000;
      for (int k = 0; k < 5; k++) begin
         sb_q.push_back({1'b1, 8'(48 + (mag / p) % 10)});
         p = p / 10;
      end
   endtask

   // Model the instruction, queue its display frame, then press the button.
   task automatic issue(input logic [17:0] ins, input int hold);
      logic [2:0]  op;
      logic [3:0]  rd;
      logic [15:0] a, b, imm, res;
      logic [31:0] prod;
      op  = ins[17:15];
      rd  = ins[14:11];
      a   = m_regs[ins[10:7]];
      b   = m_regs[ins[3:0]];
      imm = {10'd0, ins[5:0]};
      if (ins[6]) imm = 16'd0 - imm;
      prod = 32'(a) * 32'(b);
      case (op)
         3'd0: res = imm;
         3'd1: res = a + b;
         3'd2: res = a + imm;
         3'd3: res = a - b;
         3'd4: res = a - imm;
         3'd5: res = prod[15:0];
         3'd6: res = 16'h0000;
         default: res = m_regs[rd];
      endcase
      if (op == 3'd6) clear_model();
      else if (op != 3'd7) m_regs[rd] = res;
      push_frame(op, rd, res);
      instrucao  = ins;
      btn_enviar = 1'b1;
      tick(hold);
      btn_enviar = 1'b0;
      tick(3);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && sb_q.size() != 0; i++) tick(1);
      check_eq("drain", sb_q.size(), 32'd0);
      tick(8);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int en_snap;
      reset_n    = 1'b0;
      power_on   = 1'b0;
      btn_enviar = 1'b0;
      instrucao  = 18'd0;
      clear_model();
      tick(4);
      check_eq("rst_rs", LCD_RS, 32'd0);
      check_eq("rst_en", LCD_EN, 32'd0);
      check_eq("rst_rw", LCD_RW, 32'd0);
      check_eq("rst_data", LCD_DATA, 32'd0);
      check_eq("rst_on", LCD_ON, 32'd0);
      check_eq("rst_blon", LCD_BLON, 32'd0);

      reset_n  = 1'b1;
      power_on = 1'b1;
      push_init();
      tick(3);
      check_eq("pwr_on", LCD_ON, 32'd1);
      check_eq("pwr_blon", LCD_BLON, 32'd1);
      drain(500);

      // LOAD R1,+5 held long, then ADD R2=R1+R1 during the refresh.
      issue(18'b000_0001_0000_0_000101, 6);
      tick(91);
      issue(18'b001_0010_0001_000_0001, 4);
      drain(2000);
      issue(18'b111_0010_0000_0000000, 4);
      drain(1000);

      issue(18'b000_0011_0000_1_111111, 4);
      drain(1000);
      issue(18'b100_0011_0011_0_111111, 4);
      drain(1000);

      // Build 32767 by doubling 1 fifteen times (passes -32768) and subtracting 1.
      issue(18'b000_0101_0000_0_000001, 4);
      drain(1000);
      for (int i = 0; i < 15; i++) begin
         issue(18'b001_0101_0101_000_0101, 4);
         drain(1000);
      end
      issue(18'b100_0101_0101_0_000001, 4);
      drain(1000);
      issue(18'b000_0110_0000_0_000010, 4);
      drain(1000);
      issue(18'b101_0111_0101_000_0110, 4);
      drain(1000);
      issue(18'b010_1000_0111_0_000101, 4);
      drain(1000);
      issue(18'b011_1001_1000_000_0011, 4);
      drain(1000);

      // Power off: button ignored, no LCD activity, registers forced to 0.
      power_on = 1'b0;
      tick(4);
      en_snap = en_rises;
      instrucao  = 18'b000_0001_0000_0_000111;
      btn_enviar = 1'b1;
      tick(4);
      btn_enviar = 1'b0;
      tick(20);
      check_eq("off_no_en", en_rises, en_snap);
      check_eq("off_lcd_on", LCD_ON, 32'd0);
      check_eq("off_en", LCD_EN, 32'd0);
      clear_model();
      power_on = 1'b1;
      push_init();
      drain(500);
      issue(18'b111_0111_0000_0000000, 4);
      drain(1000);
      issue(18'b111_0001_0000_0000000, 4);
      drain(1000);

      issue(18'b000_0100_0000_0_001001, 4);
      drain(1000);
      issue(18'b110_0000_0000_0000000, 4);
      drain(1000);
      issue(18'b111_0100_0000_0000000, 4);
      drain(1000);

      // Reset while a byte strobe is high.
      issue(18'b000_0010_0000_0_001001, 4);
      for (int i = 0; i < 200 && !LCD_EN; i++) @(negedge clk);
      check_eq("en_seen", LCD_EN, 32'd1);
      reset_n = 1'b0;
      #1;
      check_eq("abort_en", LCD_EN, 32'd0);
      check_eq("abort_on", LCD_ON, 32'd0);
      sb_q.delete();
      clear_model();
      tick(3);
      reset_n = 1'b1;
      push_init();
      drain(500);
      issue(18'b111_0010_0000_0000000, 4);
      drain(1000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
